op_grayscale: RTL and testbench

Upstream pixel stage of the image pipeline. It drains 24-bit RGB pixels from the input FIFO, reduces each to an 8-bit gray value, and writes the result to the FIFO feeding the windowed operator (gaussian/sobel padder). It is a 2-stage, fully stallable pipeline that sustains one pixel per cycle. It also tracks frame position and flags the last pixel of each frame.

---
 rtl/op_grayscale.sv | 100 ++++++++++
 tb/tb_op_grayscale.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/op_grayscale.sv
// RGB-to-gray pixel stage: two-stage stallable pipeline between two FWFT FIFOs with frame tracking.
// Optional build macro GRAYSCALE_WEIGHTED_EN selects the 77/150/29 luma weighting instead of the exact average.
module op_grayscale #(
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 540,
    parameter int DWIDTH_IN  = 24,
    parameter int DWIDTH_OUT = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  fifo_in_rd_en,
    input  logic [DWIDTH_IN-1:0]  fifo_in_dout,
    input  logic                  fifo_in_empty,
    output logic                  fifo_out_wr_en,
    output logic [DWIDTH_OUT-1:0] fifo_out_din,
    input  logic                  fifo_out_full,
    output logic                  frame_done
);

`ifdef GRAYSCALE_WEIGHTED_EN
    localparam int SUM_W = 16;
`else
    localparam int SUM_W = 10;
`endif

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

    logic [7:0]            r, g, b;
    logic                  advance;
    logic [SUM_W-1:0]      sum_next;
    logic [DWIDTH_OUT-1:0] gray_next;

    logic [SUM_W-1:0]      s1_sum_reg;
    logic                  s1_valid_reg;
    logic [DWIDTH_OUT-1:0] s2_gray_reg;
    logic                  s2_valid_reg;
    logic [XW-1:0]         x_reg, x_next;
    logic [YW-1:0]         y_reg, y_next;

    assign r = fifo_in_dout[23:16];
    assign g = fifo_in_dout[15:8];
    assign b = fifo_in_dout[7:0];

    // One global enable: the whole pipe moves only when S2 can hand its pixel off.
    assign advance        = !s2_valid_reg || !fifo_out_full;
    assign fifo_in_rd_en  = reset && !fifo_in_empty && advance;
    assign fifo_out_wr_en = s2_valid_reg && !fifo_out_full;
    assign fifo_out_din   = s2_gray_reg;
    assign frame_done     = fifo_out_wr_en && (x_reg == X_LAST) && (y_reg == Y_LAST);

    always_comb begin
`ifdef GRAYSCALE_WEIGHTED_EN
        sum_next  = ({8'd0, r} * 16'd77) + ({8'd0, g} * 16'd150) + ({8'd0, b} * 16'd29);
        gray_next = 8'(s1_sum_reg >> 8);
`else
        sum_next  = {2'b00, r} + {2'b00, g} + {2'b00, b};
        // 683/2048 reproduces floor(sum/3) exactly over the whole 0..765 range.
        gray_next = 8'(({10'd0, s1_sum_reg} * 20'd683) >> 11);
`endif
    end

    always_comb begin
        x_next = x_reg;
        y_next = y_reg;
        if (x_reg == X_LAST) begin
            x_next = '0;
            y_next = (y_reg == Y_LAST) ? '0 : y_reg + 1'b1;
        end else begin
            x_next = x_reg + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_sum_reg   <= '0;
            s1_valid_reg <= 1'b0;
            s2_gray_reg  <= '0;
            s2_valid_reg <= 1'b0;
        end else if (advance) begin
            s1_sum_reg   <= sum_next;
            s1_valid_reg <= fifo_in_rd_en;
            s2_gray_reg  <= gray_next;
            s2_valid_reg <= s1_valid_reg;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_reg <= '0;
            y_reg <= '0;
        end else if (fifo_out_wr_en) begin
            x_reg <= x_next;
            y_reg <= y_next;
        end
    end

endmodule

// File: tb/tb_op_grayscale.sv
// Self-checking bench for op_grayscale on a 4x3 frame, with a FIFO/scoreboard model driven once per cycle.
module tb_op_grayscale;
    localparam int W = 4;
    localparam int H = 3;
    localparam int FRAME = W * H;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        fifo_in_rd_en;
    logic [23:0] fifo_in_dout = '0;
    logic        fifo_in_empty = 1'b1;
    logic        fifo_out_wr_en;
    logic [7:0]  fifo_out_din;
    logic        fifo_out_full = 1'b0;
    logic        frame_done;

    op_grayscale #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DWIDTH_IN(24), .DWIDTH_OUT(8)) dut (
        .clock(clock), .reset(reset),
        .fifo_in_rd_en(fifo_in_rd_en), .fifo_in_dout(fifo_in_dout), .fifo_in_empty(fifo_in_empty),
        .fifo_out_wr_en(fifo_out_wr_en), .fifo_out_din(fifo_out_din), .fifo_out_full(fifo_out_full),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    logic [23:0] in_q[$];
    logic [7:0]  exp_q[$];
    int  wc = 0;
    int  cyc = 0;
    logic last_rd, last_wr, last_fd;
    logic [7:0] last_din;

    function automatic logic [7:0] gray(input logic [23:0] p);
        int rr, gg, bb;
        rr = int'(p[23:16]);
        gg = int'(p[15:8]);
        bb = int'(p[7:0]);
`ifdef GRAYSCALE_WEIGHTED_EN
        return 8'((77 * rr + 150 * gg + 29 * bb) / 256);
`else
        return 8'((rr + gg + bb) / 3);
`endif
    endfunction

    // One clock cycle: drive inputs after the falling edge, then sample and score the handshakes.
    task automatic step(input logic full_in, input logic force_empty);
        logic [7:0] e;
        logic       efd;
        @(negedge clock);
        fifo_out_full = full_in;
        fifo_in_empty = force_empty || (in_q.size() == 0);
        fifo_in_dout  = (in_q.size() != 0) ? in_q[0] : 24'h0;
        #1;
        cyc++;
        last_rd = fifo_in_rd_en; last_wr = fifo_out_wr_en;
        last_fd = frame_done;    last_din = fifo_out_din;
        if (fifo_out_wr_en) begin
            tests++;
            if (fifo_out_full) begin
                fails++;
                $display("FAIL wr_while_full: wr_en=1 with full=1 at write %0d", wc);
            end
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL extra_write: got din=%0d, required no write", fifo_out_din);
            end else begin
                e = exp_q.pop_front();
                efd = ((wc % FRAME) == FRAME - 1);
                tests += 2;
                if (fifo_out_din !== e) begin
                    fails++;
                    $display("FAIL gray_value: write %0d got %0d, required %0d", wc, fifo_out_din, e);
                end
                if (frame_done !== efd) begin
                    fails++;
                    $display("FAIL frame_done: write %0d got %0b, required %0b", wc, frame_done, efd);
                end
                $display("[TB] write %0d din=%0d frame_done=%0b", wc, fifo_out_din, frame_done);
            end
            wc++;
        end else if (frame_done !== 1'b0) begin
            tests++; fails++;
            $display("FAIL frame_done_idle: got %0b without write, required 0", frame_done);
        end
        if (fifo_in_rd_en) begin
            if (fifo_in_empty) begin
                tests++; fails++;
                $display("FAIL rd_while_empty: rd_en=1 with empty=1");
            end else begin
                exp_q.push_back(gray(in_q[0]));
                void'(in_q.pop_front());
            end
        end
    endtask

    task automatic drain(input bit rand_full, input bit rand_empty);
        int budget = 6000;
        while ((in_q.size() != 0 || exp_q.size() != 0) && budget > 0) begin
            step(rand_full ? 1'($urandom_range(0, 1)) : 1'b0,
                 rand_empty ? ($urandom_range(0, 3) == 0) : 1'b0);
            budget--;
        end
        tests++;
        if (budget == 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d pixels still pending, required 0", exp_q.size() + in_q.size());
        end
    endtask

    task automatic reset_pulse();
        @(negedge clock);
        reset = 1'b0;
        fifo_in_empty = 1'b1;
        fifo_out_full = 1'b0;
        #1;
        tests += 3;
        if (fifo_out_din !== 8'd0) begin
            fails++; $display("FAIL reset_din: got %0d, required 0", fifo_out_din);
        end
        if (fifo_out_wr_en !== 1'b0 || fifo_in_rd_en !== 1'b0) begin
            fails++; $display("FAIL reset_handshake: wr_en=%0b rd_en=%0b, required 0 0", fifo_out_wr_en, fifo_in_rd_en);
        end
        if (frame_done !== 1'b0) begin
            fails++; $display("FAIL reset_frame_done: got %0b, required 0", frame_done);
        end
        exp_q.delete();
        wc = 0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset_pulse();
    endtask

    task automatic test_single_pixel();
        in_q.push_back(24'hFF_FE_FF);
        step(1'b0, 1'b0);
        tests++;
        if (last_rd !== 1'b1) begin fails++; $display("FAIL latency_pop: rd_en=%0b, required 1", last_rd); end
        step(1'b0, 1'b0);
        tests++;
        if (last_wr !== 1'b0) begin fails++; $display("FAIL latency_early: wr_en=%0b at N+1, required 0", last_wr); end
        step(1'b0, 1'b0);
        tests += 2;
        if (last_wr !== 1'b1) begin fails++; $display("FAIL latency_n2: wr_en=%0b at N+2, required 1", last_wr); end
`ifdef GRAYSCALE_WEIGHTED_EN
        if (last_din !== 8'hFE) begin fails++; $display("FAIL single_value: got %0d, required 254", last_din); end
`else
        if (last_din !== 8'd254) begin fails++; $display("FAIL single_value: got %0d, required 254", last_din); end
`endif
    endtask

    task automatic test_exhaustive_sums();
        for (int s = 0; s <= 765; s++) begin
            if (s <= 255)      in_q.push_back({8'(s), 8'd0, 8'd0});
            else if (s <= 510) in_q.push_back({8'd255, 8'(s - 255), 8'd0});
            else               in_q.push_back({8'd255, 8'd255, 8'(s - 510)});
        end
        drain(1'b0, 1'b0);
    endtask

    task automatic test_stall();
        for (int i = 0; i < 4; i++) in_q.push_back(24'($urandom));
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0);
            tests += 2;
            if (last_rd !== 1'b0 || last_wr !== 1'b0) begin
                fails++; $display("FAIL stall_handshake: rd_en=%0b wr_en=%0b, required 0 0", last_rd, last_wr);
            end
            if (last_din !== exp_q[0]) begin
                fails++; $display("FAIL stall_hold: din=%0d, required %0d", last_din, exp_q[0]);
            end
        end
        step(1'b0, 1'b0);
        tests++;
        if (last_wr !== 1'b1 || last_rd !== 1'b1) begin
            fails++; $display("FAIL stall_release: wr_en=%0b rd_en=%0b, required 1 1", last_wr, last_rd);
        end
        drain(1'b0, 1'b0);
    endtask

    task automatic test_random_full();
        for (int i = 0; i < 1000; i++) in_q.push_back(24'($urandom));
        drain(1'b1, 1'b1);
    endtask

    task automatic test_bubble();
        int first = -1, last = -1, n0;
        reset_pulse();
        n0 = wc;
        for (int i = 0; i < 20; i++) in_q.push_back(24'($urandom));
        for (int i = 0; i < 40; i++) begin
            step(1'b0, (i >= 8 && i < 13));
            if (last_wr) begin
                if (first < 0) first = cyc;
                last = cyc;
            end
        end
        tests += 2;
        if (wc - n0 != 20) begin fails++; $display("FAIL bubble_count: %0d writes, required 20", wc - n0); end
        if (last - first + 1 - 20 != 5) begin
            fails++; $display("FAIL bubble_gaps: %0d idle cycles, required 5", last - first + 1 - 20);
        end
    endtask

    task automatic test_back_to_back_frames();
        int hits[$];
        reset_pulse();
        for (int i = 0; i < 2 * FRAME; i++) in_q.push_back(24'($urandom));
        for (int i = 0; i < 2 * FRAME + 10; i++) begin
            step(1'b0, 1'b0);
            if (last_fd) hits.push_back(wc);
        end
        tests++;
        if (hits.size() != 2 || hits[0] != FRAME || hits[1] != 2 * FRAME) begin
            fails++;
            $display("FAIL frame_pulses: %0d pulses first at write %0d, required 2 at writes 12 and 24",
                     hits.size(), (hits.size() != 0) ? hits[0] : -1);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n = 0;
        bit seen = 0;
        for (int i = 0; i < 5; i++) in_q.push_back(24'($urandom));
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 2; i++) in_q.push_back(24'($urandom));
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        reset_pulse();
        for (int i = 0; i < FRAME; i++) in_q.push_back(24'($urandom));
        for (int i = 0; i < FRAME + 10 && !seen; i++) begin
            step(1'b0, 1'b0);
            if (last_wr) n++;
            if (last_fd) seen = 1;
        end
        tests++;
        if (!seen || n != FRAME) begin
            fails++; $display("FAIL reset_realign: frame_done after %0d writes (seen=%0b), required 12", n, seen);
        end
        drain(1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_exhaustive_sums();
        test_stall();
        test_random_full();
        test_bubble();
        test_back_to_back_frames();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
